// File: rtl/riscv_branch_predictor_pkg.sv
// Shared types and helpers for the dynamic branch predictor: BTB entry layout,
// the default counter width and taken threshold, and the saturating-counter step.
package riscv_bp_pkg;

   localparam int BP_PC_W         = 32;
   localparam int BP_CNT_W        = 2;
   localparam int BP_CNT_TAKEN_TH = 2 ** (BP_CNT_W - 1);

   // Tag is stored zero-extended so one entry type serves every ENTRIES setting.
   typedef struct packed {
      logic               valid;
      logic [BP_PC_W-1:0] tag;
      logic [BP_PC_W-1:0] target;
   } bp_entry_t;

   function automatic int unsigned bp_sat_update(input int unsigned cnt,
                                                 input logic        taken,
                                                 input int unsigned cnt_max);
      if (taken) begin
         return (cnt >= cnt_max) ? cnt_max : cnt + 1;
      end
      return (cnt == 0) ? 0 : cnt - 1;
   endfunction

endpackage

// File: rtl/riscv_branch_predictor_if.sv
// Fetch-lookup / EX-resolve / statistics bundle between the core and the branch predictor.
// The core drives through master; the predictor answers through slave.
interface riscv_branch_predictor_if #(
   parameter int PC_W = 32
);
   logic [PC_W-1:0] f_pc;
   logic            f_pred_taken;
   logic [PC_W-1:0] f_pred_target;
   logic            ex_valid;
   logic [PC_W-1:0] ex_pc;
   logic            ex_taken;
   logic [PC_W-1:0] ex_target;
   logic            ex_pred_taken;
   logic [PC_W-1:0] ex_pred_target;
   logic            ex_mispredict;
   logic [PC_W-1:0] ex_redirect_pc;
   logic [31:0]     stat_branches;
   logic [31:0]     stat_mispredicts;

   modport master (
      output f_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
      input  f_pred_taken, f_pred_target, ex_mispredict, ex_redirect_pc,
             stat_branches, stat_mispredicts
   );

   modport slave (
      input  f_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
      output f_pred_taken, f_pred_target, ex_mispredict, ex_redirect_pc,
             stat_branches, stat_mispredicts
   );
endinterface

// File: rtl/riscv_branch_predictor_sat_counter.sv
// Per-entry saturating direction counter: inc on taken, dec on not-taken, load weakly-taken on allocate.
//   state (CNT_W=2) | meaning
//   SNT 0           | strongly not-taken
//   WNT 1           | weakly not-taken (reset value)
//   WT  2           | weakly taken (allocation value)
//   ST  3           | strongly taken
module bp_sat_counter
   import riscv_bp_pkg::*;
#(
   parameter int CNT_W    = 2,
   parameter int INIT_CNT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_taken,
   input  logic             i_alloc,
   output logic [CNT_W-1:0] o_cnt
);

   localparam int unsigned      CNT_MAX    = (2 ** CNT_W) - 1;
   localparam logic [CNT_W-1:0] WEAK_TAKEN = CNT_W'(2 ** (CNT_W - 1));

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_alloc) begin
         w_cnt_nxt = WEAK_TAKEN;
      end else if (i_en) begin
         w_cnt_nxt = CNT_W'(bp_sat_update(32'(r_cnt), i_taken, CNT_MAX));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= CNT_W'(INIT_CNT);
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/riscv_branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters: combinational fetch lookup,
// EX-stage update, mispredict/redirect generation and branch statistics.
module riscv_branch_predictor
   import riscv_bp_pkg::*;
#(
   parameter int ENTRIES  = 16,
   parameter int CNT_W    = 2,
   parameter int INIT_CNT = 1,
   parameter int PC_W     = 32
) (
   input logic                      clk,
   input logic                      rst,
   riscv_branch_predictor_if.slave  bp
);

   localparam int               IDX_W    = $clog2(ENTRIES);
   localparam logic [CNT_W-1:0] TAKEN_TH = CNT_W'(2 ** (CNT_W - 1));

   bp_entry_t          r_ent [ENTRIES];
   logic [CNT_W-1:0]   w_cnt [ENTRIES];
   logic [ENTRIES-1:0] w_cnt_en;
   logic [ENTRIES-1:0] w_cnt_alloc;
   logic [31:0]        r_stat_br;
   logic [31:0]        r_stat_mis;

   logic [IDX_W-1:0]   w_f_idx;
   logic [IDX_W-1:0]   w_ex_idx;
   logic [BP_PC_W-1:0] w_f_tag;
   logic [BP_PC_W-1:0] w_ex_tag;
   logic               w_f_hit;
   logic               w_ex_hit;
   logic               w_unused_lsbs;

   assign w_f_idx  = bp.f_pc[IDX_W+1:2];
   assign w_ex_idx = bp.ex_pc[IDX_W+1:2];
   assign w_f_tag  = BP_PC_W'(bp.f_pc[PC_W-1:IDX_W+2]);
   assign w_ex_tag = BP_PC_W'(bp.ex_pc[PC_W-1:IDX_W+2]);

   // Instructions are word aligned, so the low PC bits never address the table.
   assign w_unused_lsbs = ^{bp.f_pc[1:0], bp.ex_pc[1:0]};

   assign w_f_hit          = r_ent[w_f_idx].valid && (r_ent[w_f_idx].tag == w_f_tag);
   assign bp.f_pred_taken  = w_f_hit && (w_cnt[w_f_idx] >= TAKEN_TH);
   assign bp.f_pred_target = bp.f_pred_taken ? r_ent[w_f_idx].target[PC_W-1:0]
                                             : bp.f_pc + PC_W'(4);

   assign bp.ex_mispredict  = bp.ex_valid &&
                              ((bp.ex_taken != bp.ex_pred_taken) ||
                               (bp.ex_taken && (bp.ex_pred_target != bp.ex_target)));
   assign bp.ex_redirect_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + PC_W'(4);

   assign w_ex_hit = r_ent[w_ex_idx].valid && (r_ent[w_ex_idx].tag == w_ex_tag);

   // A hit trains the counter; a taken miss claims the slot; a not-taken miss is ignored.
   always_comb begin
      w_cnt_en    = '0;
      w_cnt_alloc = '0;
      if (bp.ex_valid) begin
         if (w_ex_hit) begin
            w_cnt_en[w_ex_idx] = 1'b1;
         end else if (bp.ex_taken) begin
            w_cnt_alloc[w_ex_idx] = 1'b1;
         end
      end
   end

   // Taken updates rewrite valid/tag/target for both the hit and the allocate case.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_ent[i] <= '0;
         end
      end else if (bp.ex_valid && bp.ex_taken) begin
         r_ent[w_ex_idx].valid  <= 1'b1;
         r_ent[w_ex_idx].tag    <= w_ex_tag;
         r_ent[w_ex_idx].target <= BP_PC_W'(bp.ex_target);
      end
   end

   for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
      bp_sat_counter #(
         .CNT_W    (CNT_W),
         .INIT_CNT (INIT_CNT)
      ) u_cnt (
         .clk     (clk),
         .rst     (rst),
         .i_en    (w_cnt_en[g]),
         .i_taken (bp.ex_taken),
         .i_alloc (w_cnt_alloc[g]),
         .o_cnt   (w_cnt[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_br  <= '0;
         r_stat_mis <= '0;
      end else begin
         r_stat_br  <= r_stat_br + 32'(bp.ex_valid);
         r_stat_mis <= r_stat_mis + 32'(bp.ex_mispredict);
      end
   end

   assign bp.stat_branches    = r_stat_br;
   assign bp.stat_mispredicts = r_stat_mis;

endmodule

// File: tb/tb_riscv_branch_predictor.sv
// Directed bench for riscv_branch_predictor: reset, cold allocate, saturation,
// same-cycle lookup, aliasing, no-allocate on not-taken miss and a trained loop.
module tb_riscv_branch_predictor;
   import riscv_bp_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   riscv_branch_predictor_if #(.PC_W(32)) bp_if ();

   riscv_branch_predictor #(
      .ENTRIES  (16),
      .CNT_W    (2),
      .INIT_CNT (1),
      .PC_W     (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bp_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
      bp_if.ex_valid       = v;
      bp_if.ex_pc          = pc;
      bp_if.ex_taken       = tk;
      bp_if.ex_target      = tgt;
      bp_if.ex_pred_taken  = ptk;
      bp_if.ex_pred_target = ptgt;
   endtask

   task automatic chk_fetch(input string tag, input logic [31:0] pc,
                            input logic exp_tk, input logic [31:0] exp_tgt);
      bp_if.f_pc = pc;
      #1;
      chk({tag, "_taken"}, 32'(bp_if.f_pred_taken), 32'(exp_tk));
      chk({tag, "_target"}, bp_if.f_pred_target, exp_tgt);
   endtask

   task automatic chk_stats(input string tag, input logic [31:0] br, input logic [31:0] mis);
      chk({tag, "_branches"}, bp_if.stat_branches, br);
      chk({tag, "_mispredicts"}, bp_if.stat_mispredicts, mis);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bp_if.f_pc = 32'h18;
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

      // reset for one edge
      tick();
      rst = 1'b0;
      #1;
      chk_fetch("reset", 32'h18, 1'b0, 32'h1C);
      chk_stats("reset", 32'd0, 32'd0);

      // invalid EX never flags a mispredict
      set_ex(1'b0, 32'h18, 1'b1, 32'h0, 1'b0, 32'h1C);
      #1;
      chk("idle_mispredict", 32'(bp_if.ex_mispredict), 32'd0);

      // cold taken branch: miss allocates weakly taken (cnt=2)
      set_ex(1'b1, 32'h18, 1'b1, 32'h0, 1'b0, 32'h1C);
      #1;
      chk("cold_mispredict", 32'(bp_if.ex_mispredict), 32'd1);
      chk("cold_redirect", bp_if.ex_redirect_pc, 32'h0);
      tick();
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_fetch("cold_after", 32'h18, 1'b1, 32'h0);
      chk_stats("cold", 32'd1, 32'd1);

      // four correctly predicted taken updates: cnt 2 -> 3 and stays there
      for (int i = 0; i < 4; i++) begin
         set_ex(1'b1, 32'h18, 1'b1, 32'h0, 1'b1, 32'h0);
         #1;
         chk("sat_taken_mispredict", 32'(bp_if.ex_mispredict), 32'd0);
         tick();
      end
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_stats("sat", 32'd5, 32'd1);

      // first not-taken: cnt 3 -> 2, still taken
      set_ex(1'b1, 32'h18, 1'b0, 32'h0, 1'b1, 32'h0);
      #1;
      chk("nt1_mispredict", 32'(bp_if.ex_mispredict), 32'd1);
      chk("nt1_redirect", bp_if.ex_redirect_pc, 32'h1C);
      tick();
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_fetch("nt1_after", 32'h18, 1'b1, 32'h0);

      // second not-taken: cnt 2 -> 1, now predicts fall-through
      set_ex(1'b1, 32'h18, 1'b0, 32'h0, 1'b1, 32'h0);
      #1;
      chk("nt2_mispredict", 32'(bp_if.ex_mispredict), 32'd1);
      chk("nt2_redirect", bp_if.ex_redirect_pc, 32'h1C);
      tick();
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_fetch("nt2_after", 32'h18, 1'b0, 32'h1C);
      chk_stats("nt2", 32'd7, 32'd3);

      // same-cycle lookup sees pre-update cnt=1; next cycle sees cnt=2
      set_ex(1'b1, 32'h18, 1'b1, 32'h0, 1'b0, 32'h1C);
      chk_fetch("same_cycle", 32'h18, 1'b0, 32'h1C);
      tick();
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_fetch("same_next", 32'h18, 1'b1, 32'h0);
      chk_stats("same", 32'd8, 32'd4);

      // drive to the bottom: cnt 2 -> 1 -> 0 -> 0, then one taken -> 1
      for (int i = 0; i < 3; i++) begin
         set_ex(1'b1, 32'h18, 1'b0, 32'h0, 1'b0, 32'h1C);
         #1;
         chk("low_nt_mispredict", 32'(bp_if.ex_mispredict), 32'd0);
         tick();
      end
      set_ex(1'b1, 32'h18, 1'b1, 32'h0, 1'b0, 32'h1C);
      tick();
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_fetch("low_sat", 32'h18, 1'b0, 32'h1C);
      chk_stats("low", 32'd12, 32'd5);

      // retrain 0x18 (cnt 1 -> 2), then alias 0x58 onto the same index
      set_ex(1'b1, 32'h18, 1'b1, 32'h0, 1'b0, 32'h1C);
      tick();
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_fetch("alias_pre", 32'h18, 1'b1, 32'h0);
      set_ex(1'b1, 32'h58, 1'b1, 32'h40, 1'b0, 32'h5C);
      #1;
      chk("alias_mispredict", 32'(bp_if.ex_mispredict), 32'd1);
      tick();
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_fetch("alias_old", 32'h18, 1'b0, 32'h1C);
      chk_fetch("alias_new", 32'h58, 1'b1, 32'h40);

      // a not-taken miss must not allocate
      set_ex(1'b1, 32'h28, 1'b0, 32'h0, 1'b0, 32'h2C);
      tick();
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_fetch("nt_miss", 32'h28, 1'b0, 32'h2C);
      chk_stats("alias", 32'd15, 32'd7);

      // predicted-taken with a wrong target is a mispredict
      set_ex(1'b1, 32'h58, 1'b1, 32'h44, 1'b1, 32'h40);
      #1;
      chk("bad_target_mispredict", 32'(bp_if.ex_mispredict), 32'd1);
      chk("bad_target_redirect", bp_if.ex_redirect_pc, 32'h44);
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

      // reset wins over a coincident update
      rst = 1'b1;
      set_ex(1'b1, 32'h18, 1'b1, 32'h0, 1'b0, 32'h1C);
      tick();
      rst = 1'b0;
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_fetch("rst_override", 32'h18, 1'b0, 32'h1C);
      chk_fetch("rst_alias_gone", 32'h58, 1'b0, 32'h5C);
      chk_stats("rst_override", 32'd0, 32'd0);

      // loop body: bne at 0x08 falls through, back-edge bne at 0x18 -> 0x0, 3 iterations
      for (int it = 1; it <= 3; it++) begin
         chk_fetch("loop_fwd_fetch", 32'h08, 1'b0, 32'h0C);
         set_ex(1'b1, 32'h08, 1'b0, 32'h0, 1'b0, 32'h0C);
         #1;
         chk("loop_fwd_mispredict", 32'(bp_if.ex_mispredict), 32'd0);
         tick();
         set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
         if (it == 1) begin
            chk_fetch("loop_back_fetch_cold", 32'h18, 1'b0, 32'h1C);
            set_ex(1'b1, 32'h18, 1'b1, 32'h0, 1'b0, 32'h1C);
            #1;
            chk("loop_back_mispredict_cold", 32'(bp_if.ex_mispredict), 32'd1);
         end else begin
            chk_fetch("loop_back_fetch_warm", 32'h18, 1'b1, 32'h0);
            set_ex(1'b1, 32'h18, 1'b1, 32'h0, 1'b1, 32'h0);
            #1;
            chk("loop_back_mispredict_warm", 32'(bp_if.ex_mispredict), 32'd0);
         end
         tick();
         set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      end
      chk_stats("loop", 32'd6, 32'd1);
      chk("taken_threshold_default", 32'(BP_CNT_TAKEN_TH), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
